// File: rtl/nibble_serial_adder.sv
// Wide-operand adder that processes one 4-bit nibble per cycle through a
// carry-select nibble stage, with valid/ready handshakes on both sides.

module CarrySelectNibble (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [2:0] lowSum;
  logic [2:0] highSum0;
  logic [2:0] highSum1;

  // The upper bit pair is precomputed for both possible carries, then picked by the low pair's carry.
  always_comb begin
    lowSum   = {1'b0, a_i[1:0]} + {1'b0, b_i[1:0]} + {2'b00, c_i};
    highSum0 = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]};
    highSum1 = highSum0 + 3'd1;
    s_o      = {(lowSum[2] ? highSum1[1:0] : highSum0[1:0]), lowSum[1:0]};
    c_o      = lowSum[2] ? highSum1[2] : highSum0[2];
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : gWidthCheck
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aOp_q, aOp_d;
  logic [WIDTH-1:0] bOp_q, bOp_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [3:0]       stageA;
  logic [3:0]       stageB;
  logic [3:0]       stageSum;
  logic             stageCarry;

  assign stageA = aOp_q[4*idx_q +: 4];
  assign stageB = bOp_q[4*idx_q +: 4];

  CarrySelectNibble uStage (
    .a_i (stageA),
    .b_i (stageB),
    .c_i (carry_q),
    .s_o (stageSum),
    .c_o (stageCarry)
  );

  always_comb begin
    state_d = state_q;
    aOp_d   = aOp_q;
    bOp_d   = bOp_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          aOp_d   = a;
          bOp_d   = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[4*idx_q +: 4] = stageSum;
        carry_d             = stageCarry;
        // The stage sum's top bit on the final nibble is the result MSB, so overflow is decided here.
        if (idx_q == LAST_IDX) begin
          cout_d  = stageCarry;
          ovf_d   = (aOp_q[WIDTH-1] == bOp_q[WIDTH-1]) && (stageSum[3] != aOp_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aOp_q   <= '0;
      bOp_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      aOp_q   <= aOp_d;
      bOp_q   <= bOp_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed vector bench for nibble_serial_adder (WIDTH=16): table of
// hand-computed sums plus backpressure and reset-mid-operation sequences.

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation from the negedge; returns the accept-to-out_valid latency or -1 on timeout.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                               output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  initial begin
    int lat;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[8] = '{16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'h0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    checkOutput("reset ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      checkOutput($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].sum));
      checkOutput($sformatf("vec%0d cout", i), 32'(cout), 32'(vecs[i].cout));
      checkOutput($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      @(negedge clk);
      checkOutput($sformatf("vec%0d in_ready after done", i), 32'(in_ready), 32'd1);
      checkOutput($sformatf("vec%0d out_valid after done", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: result must hold while new operands are offered.
    out_ready = 1'b0;
    applyStimulus(16'h7000, 16'h7000, 1'b0, lat);
    checkOutput("bp latency", 32'(lat), 32'd4);
    for (int c = 0; c < 10; c++) begin
      a        = 16'h1111 * 16'(c + 1);
      b        = 16'h0F0F;
      cin      = 1'b1;
      in_valid = c[0];
      @(negedge clk);
      checkOutput($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      checkOutput($sformatf("bp%0d sum", c), 32'(sum), 32'hE000);
      checkOutput($sformatf("bp%0d cout", c), 32'(cout), 32'd0);
      checkOutput($sformatf("bp%0d ovf", c), 32'(ovf), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp release out_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h1111, 16'h2222, 1'b0, lat);
    checkOutput("post-bp latency", 32'(lat), 32'd4);
    checkOutput("post-bp sum", 32'(sum), 32'h3333);
    @(negedge clk);

    // Reset two RUN edges into an operation.
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrun reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrun reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrun reset sum", 32'(sum), 32'h0);
    checkOutput("midrun reset cout", 32'(cout), 32'd0);
    checkOutput("midrun reset ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("post-reset%0d out_valid", c), 32'(out_valid), 32'd0);
      checkOutput($sformatf("post-reset%0d in_ready", c), 32'(in_ready), 32'd1);
    end
    applyStimulus(16'h0F0F, 16'hF0F0, 1'b0, lat);
    checkOutput("after reset latency", 32'(lat), 32'd4);
    checkOutput("after reset sum", 32'(sum), 32'hFFFF);
    checkOutput("after reset cout", 32'(cout), 32'd0);
    checkOutput("after reset ovf", 32'(ovf), 32'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
